// File: rtl/alt_vipcti131_common_sync_filter.sv
// alt_vipcti131_common_sync_filter
// Multi-channel synchroniser with a per-channel consecutive-sample glitch
// filter and registered rise/fall/changed edge pulses. Every channel is
// independent; the filter state is implied by comparing the sampled value
// with data_out (equal = STABLE, different = PENDING).
`timescale 1ns/1ps

module alt_vipcti131_common_sync_filter #(
  parameter int               CLOCKS_ARE_SAME = 0,
  parameter int               WIDTH           = 1,
  parameter int               SYNC_STAGES     = 2,
  parameter int               FILTER_CYCLES   = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE     = '0
) (
  input  logic             sync_clock,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_in,
  output logic [WIDTH-1:0] data_out,
  output logic [WIDTH-1:0] rise_pulse,
  output logic [WIDTH-1:0] fall_pulse,
  output logic             changed
);

  // Counter holds the number of differing samples already seen; a width of
  // one bit is kept when no filtering is requested so the logic stays legal.
  localparam int              CNT_W    = (FILTER_CYCLES > 1) ? $clog2(FILTER_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [WIDTH-1:0] w_sampled;
  logic [WIDTH-1:0] w_update;
  logic [CNT_W-1:0] w_countNext [WIDTH];

  logic [CNT_W-1:0] r_count [WIDTH];
  logic [WIDTH-1:0] r_dataOut;
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;
  logic             r_changed;

  generate
    if (CLOCKS_ARE_SAME == 0) begin : g_sync
      (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS; -name SDC_STATEMENT set_false_path -to [get_keepers {*alt_vipcti131_common_sync_filter*r_syncFirst*}]" *)
      logic [WIDTH-1:0] r_syncFirst;
      (* altera_attribute = "-name SYNCHRONIZER_IDENTIFICATION FORCED_IF_ASYNCHRONOUS" *)
      logic [WIDTH-1:0] r_syncRest [SYNC_STAGES-1];

      // Flop chain that carries the asynchronous inputs into sync_clock.
      always_ff @(posedge sync_clock or negedge rst_n) begin
        if (!rst_n) begin
          r_syncFirst <= RESET_VALUE;
          for (int s = 0; s < SYNC_STAGES - 1; s++) begin
            r_syncRest[s] <= RESET_VALUE;
          end
        end else begin
          r_syncFirst   <= data_in;
          r_syncRest[0] <= r_syncFirst;
          for (int s = 1; s < SYNC_STAGES - 1; s++) begin
            r_syncRest[s] <= r_syncRest[s-1];
          end
        end
      end

      assign w_sampled = r_syncRest[SYNC_STAGES-2];
    end else begin : g_bypass
      // Source is already in this clock domain, so no chain is needed.
      assign w_sampled = data_in;
    end
  endgenerate

  // Decide per channel whether this edge commits an update or just counts.
  always_comb begin
    w_update = '0;
    for (int i = 0; i < WIDTH; i++) begin
      w_countNext[i] = '0;
      if (w_sampled[i] != r_dataOut[i]) begin
        if (r_count[i] == CNT_LAST) begin
          w_update[i] = 1'b1;
        end else begin
          w_countNext[i] = r_count[i] + CNT_W'(1);
        end
      end
    end
  end

  // Stability counters; any return to the current output clears them.
  always_ff @(posedge sync_clock or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < WIDTH; i++) begin
        r_count[i] <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        r_count[i] <= w_countNext[i];
      end
    end
  end

  // Filtered output and the edge pulses that mark its first updated cycle.
  always_ff @(posedge sync_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_dataOut <= RESET_VALUE;
      r_rise    <= '0;
      r_fall    <= '0;
      r_changed <= 1'b0;
    end else begin
      r_dataOut <= (r_dataOut & ~w_update) | (w_sampled & w_update);
      r_rise    <= w_update & w_sampled;
      r_fall    <= w_update & ~w_sampled;
      r_changed <= |w_update;
    end
  end

  assign data_out   = r_dataOut;
  assign rise_pulse = r_rise;
  assign fall_pulse = r_fall;
  assign changed    = r_changed;

endmodule
